piso_8: RTL and testbench
=========================

# piso_8

Parallel-in, serial-out transmitter for 8-bit words. It accepts a word through a valid/ready load handshake and shifts it out one bit per clock, with a complementary serial output, framing strobes and a sent-word counter. It is the transmit end of the basic register datapath, feeding serial links or a matching serial-to-parallel capture register. Back-to-back words stream with no idle cycle.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- data  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  source offers `data`.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_bar  output  1  always the complement of `sout`, including during reset.
- sout_valid  output  1  `sout` carries a frame bit this cycle.
- sout_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is being shifted.
- words_sent  output  8  count of fully transmitted words; wraps 255 -> 0.

## Operation
- States are IDLE and SHIFT. There is a shift register `sreg[WIDTH-1:0]` and a bit counter `cnt` of width clog2(WIDTH).
- Accept: the load is accepted on a rising edge when load_valid=1 and load_ready=1. `sreg` takes `data`, `cnt` is set to 0, and the state becomes SHIFT.
- load_ready = (state==IDLE) or (state==SHIFT and cnt==WIDTH-1). It is a combinational function of state and cnt only, with no path from load_valid.
- In SHIFT:
  - `sout` = `sreg[WIDTH-1]` when MSB_FIRST=1, otherwise `sreg[0]`.
  - Each clock shifts `sreg` one place toward the output end, zero-filled, and increments `cnt`.
- sout_valid = busy = (state==SHIFT).
- sout_last = (state==SHIFT and cnt==WIDTH-1).
- At the last bit:
  - With an accepted load, the block reloads `sreg`, clears `cnt` and stays in SHIFT.
  - Without a load, it goes to IDLE.
  - In both cases `words_sent` increments by 1, modulo 256.
- In IDLE, `sout`=0 and `sout_bar`=1.
- load_valid while load_ready=0 is ignored. The word is not queued, and the source must hold it.
- Changes on `data` outside an accepted load have no effect on the word in flight.

## Timing
- Reset (rst=0), applied asynchronously at any time including mid-word:
  - State goes to IDLE; sreg=0, cnt=0.
  - sout=0, sout_bar=1, sout_valid=0, sout_last=0, busy=0, words_sent=0, load_ready=1.
  - The word in flight is discarded and not counted.
- After reset release, the first edge at which a load can be accepted is the first rising edge with rst=1.
- Latency: with the load accepted at edge E0, frame bit k is presented between edges E0+k and E0+k+1, for k=0..WIDTH-1.
- sout_last is high during bit WIDTH-1. words_sent updates at edge E0+WIDTH.
- Throughput: one word per WIDTH cycles when load_valid is held high. There is no gap between the last bit of word n and the first bit of word n+1.
- A word loaded in IDLE produces its first bit in the cycle directly after acceptance. There is no start bit and no parity.

## Test plan
- Reset then single word, with WIDTH=8 and MSB_FIRST=1:
  - Hold rst=0 for 5 cycles: sout=0, sout_bar=1, load_ready=1, words_sent=0.
  - Release rst, then load 23 (0x17): sout over the next 8 cycles is 0,0,0,1,0,1,1,1.
  - sout_last is high only on the 8th bit. Afterwards words_sent=1, busy=0, load_ready=1.
- LSB first, with MSB_FIRST=0:
  - Load 50 (0x32): sout is 0,1,0,0,1,1,0,0.
  - sout_bar is the inverse on every cycle.
- Back-to-back streaming:
  - Hold load_valid=1 with data 2, then 11 presented at the sout_last cycle.
  - Required: 16 consecutive sout_valid cycles with bit sequence 00000010 00001011.
  - load_ready is high only in the sout_last cycles; words_sent goes 0 -> 1 -> 2.
- Ignored load and data change:
  - Load 60, then during bit 3 assert load_valid with data 112 and toggle `data`.
  - Required: the serial stream remains 00111100 and 112 is not sent until load_ready=1.
- Reset mid-word:
  - Load 0xFF and assert rst=0 asynchronously, between clock edges, during bit 4.
  - Required: sout drops to 0 and sout_valid to 0 immediately, without waiting for an edge; words_sent=0.
  - The next load after release transmits cleanly from bit 0.
- Counter wrap:
  - Stream 256 words of value 1.
  - Required: words_sent wraps to 0 after the 256th sout_last. Word 257 gives words_sent=1.

Source files
------------

// File: rtl/piso_8_if.sv
// Load handshake and serial output bundle for the piso_8 transmitter.
// The master modport is the word source; the slave modport is the transmitter.
interface piso_8_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_bar;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;
    logic [7:0]       words_sent;

    modport master (
        output data,
        output load_valid,
        input  load_ready,
        input  sout,
        input  sout_bar,
        input  sout_valid,
        input  sout_last,
        input  busy,
        input  words_sent
    );

    modport slave (
        input  data,
        input  load_valid,
        output load_ready,
        output sout,
        output sout_bar,
        output sout_valid,
        output sout_last,
        output busy,
        output words_sent
    );
endinterface

// File: rtl/piso_8.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock,
// gapless back-to-back streaming, complementary output and a sent-word counter.
module piso_8 #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    piso_8_if.slave bus
);
    localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             head_bit;
    logic [CW-1:0]    cnt;
    logic [7:0]       words_sent;
    logic             at_last;
    logic             load_ready;
    logic             accept;

    // Output end of the shift register and the zero-filled shift toward it.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head_bit     = sreg[WIDTH-1];
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bit     = sreg[0];
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

    // Ready depends only on state and cnt so no path exists from load_valid.
    always_comb begin
        at_last    = (state == SHIFT) && (cnt == CNT_LAST);
        load_ready = (state == IDLE) || at_last;
        accept     = bus.load_valid && load_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = load_ready;
        bus.sout_valid = (state == SHIFT);
        bus.busy       = (state == SHIFT);
        bus.sout_last  = at_last;
        bus.sout       = (state == SHIFT) && head_bit;
        bus.sout_bar   = !((state == SHIFT) && head_bit);
        bus.words_sent = words_sent;
    end

    // A reload at the last bit takes priority over the shift, keeping the stream gapless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg       <= '0;
            cnt        <= '0;
            words_sent <= '0;
        end else begin
            if (accept) begin
                sreg <= bus.data;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                sreg <= sreg_shifted;
                cnt  <= at_last ? '0 : cnt + CW'(1);
            end
            if (at_last) begin
                words_sent <= words_sent + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_piso_8.sv
// Bench for piso_8: MSB-first and LSB-first instances share one random/directed
// stimulus and are compared every cycle against queue-of-bits reference models.
module tb_piso_8;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         lval;
    logic [W-1:0] din;

    int n_cmp;
    int n_err;

    // Reference: pending frame bits in transmit order, plus completed-word count.
    bit       qm[$];
    bit       ql[$];
    bit [7:0] wsent;

    piso_8_if #(.WIDTH(W)) bus_m ();
    piso_8_if #(.WIDTH(W)) bus_l ();

    assign bus_m.data       = din;
    assign bus_m.load_valid = lval;
    assign bus_l.data       = din;
    assign bus_l.load_valid = lval;

    piso_8 #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    piso_8 #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        wsent = '0;
    endtask

    task automatic model_edge(input bit acc, input logic [W-1:0] d);
        if (qm.size() > 0) begin
            if (qm.size() == 1) wsent++;
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (acc) begin
            for (int unsigned k = 0; k < W; k++) begin
                qm.push_back(d[W-1-k]);
                ql.push_back(d[k]);
            end
        end
    endtask

    task automatic check_all();
        bit em;
        bit el;
        em = (qm.size() > 0) ? qm[0] : 1'b0;
        el = (ql.size() > 0) ? ql[0] : 1'b0;
        check("m.sout",       32'(bus_m.sout),       32'(em));
        check("m.sout_bar",   32'(bus_m.sout_bar),   32'(!em));
        check("m.sout_valid", 32'(bus_m.sout_valid), 32'(qm.size() > 0));
        check("m.sout_last",  32'(bus_m.sout_last),  32'(qm.size() == 1));
        check("m.busy",       32'(bus_m.busy),       32'(qm.size() > 0));
        check("m.load_ready", 32'(bus_m.load_ready), 32'(qm.size() <= 1));
        check("m.words_sent", 32'(bus_m.words_sent), 32'(wsent));
        check("l.sout",       32'(bus_l.sout),       32'(el));
        check("l.sout_bar",   32'(bus_l.sout_bar),   32'(!el));
        check("l.sout_valid", 32'(bus_l.sout_valid), 32'(ql.size() > 0));
        check("l.sout_last",  32'(bus_l.sout_last),  32'(ql.size() == 1));
        check("l.load_ready", 32'(bus_l.load_ready), 32'(ql.size() <= 1));
        check("l.words_sent", 32'(bus_l.words_sent), 32'(wsent));
    endtask

    // One clock: drive inputs, advance model at the edge, check on the falling edge.
    task automatic tick(input logic lv, input logic [W-1:0] d);
        bit acc;
        lval = lv;
        din  = d;
        acc  = lv && (qm.size() <= 1);
        @(posedge clk);
        model_edge(acc, d);
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between edges; outputs must react before the next edge.
    task automatic async_reset();
        lval = 1'b0;
        @(posedge clk);
        model_edge(1'b0, '0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] cap_m;
        logic [7:0] cap_l;
        bool_t_dummy: begin end
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        lval  = 1'b0;
        din   = '0;
        model_reset();

        repeat (5) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;

        // Single word 0x17; the LSB-first instance carries the same word.
        cap_m = '0;
        cap_l = '0;
        tick(1'b1, 8'h17);
        for (int unsigned i = 0; i < 8; i++) begin
            cap_m = {cap_m[6:0], bus_m.sout};
            cap_l = {bus_l.sout, cap_l[7:1]};
            if (i < 7) tick(1'b0, 8'hAA);
        end
        check("cap_msb_17", 32'(cap_m), 32'h17);
        check("cap_lsb_17", 32'(cap_l), 32'h17);
        repeat (2) tick(1'b0, '0);
        check("single_count", 32'(bus_m.words_sent), 32'd1);

        // LSB-first word 0x32 captured from the LSB instance.
        tick(1'b1, 8'h32);
        cap_l = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cap_l = {bus_l.sout, cap_l[7:1]};
            if (i < 7) tick(1'b0, '0);
        end
        check("cap_lsb_32", 32'(cap_l), 32'h32);
        repeat (2) tick(1'b0, '0);

        // Back-to-back: 2 held, 11 presented in the last-bit cycle.
        async_reset();
        tick(1'b1, 8'd2);
        repeat (7) tick(1'b1, 8'd2);
        tick(1'b1, 8'd11);
        repeat (9) tick(1'b0, '0);
        check("b2b_count", 32'(bus_m.words_sent), 32'd2);

        // Ignored load with toggling data while not ready.
        tick(1'b1, 8'd60);
        repeat (3) tick(1'b0, '0);
        for (int unsigned i = 0; i < 20; i++) begin
            bit rdy;
            rdy = (qm.size() <= 1);
            tick(1'b1, rdy ? 8'd112 : 8'($urandom));
            if (rdy) break;
        end
        repeat (10) tick(1'b0, '0);

        // Reset in the middle of a 0xFF word, then a clean word.
        tick(1'b1, 8'hFF);
        repeat (3) tick(1'b0, '0);
        async_reset();
        check("midrst_count", 32'(bus_m.words_sent), 32'd0);
        tick(1'b1, 8'hA5);
        repeat (9) tick(1'b0, '0);

        // Counter wrap: 257 words of value 1 streamed continuously.
        async_reset();
        for (int unsigned i = 0; i < 1 + 256 * 8; i++) tick(1'b1, 8'd1);
        repeat (9) tick(1'b0, '0);
        check("wrap_count", 32'(bus_m.words_sent), 32'd1);

        // Random traffic with occasional asynchronous resets.
        for (int unsigned i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
